// File: rtl/word_split_pkg.sv
// rtl/word_split_pkg.sv - shared state encoding and default sizes for word_split
package word_split_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_DEF    = 4;

endpackage

// File: rtl/word_split_if.sv
// rtl/word_split_if.sv - word-in / lane-out handshake bundle; last_out exists only with WORD_SPLIT_LAST_EN
interface word_split_if
  import word_split_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM    = NUM_DEF
);

  logic [NUM*DATA_W-1:0] data_in;
  logic                  valid_in;
  logic                  ready_out;
  logic [DATA_W-1:0]     data_out;
  logic                  valid_out;
  logic                  ready_in;
`ifdef WORD_SPLIT_LAST_EN
  logic                  last_out;
`endif

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out
`ifdef WORD_SPLIT_LAST_EN
    , last_out
`endif
  );

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out
`ifdef WORD_SPLIT_LAST_EN
    , last_out
`endif
  );

endinterface

// File: rtl/word_split_lane_mux.sv
// rtl/word_split_lane_mux.sv - selects one DATA_W lane of a held word by emission index
module lane_mux
  import word_split_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM       = NUM_DEF,
  parameter int MSB_FIRST = 0
) (
  input  logic [NUM*DATA_W-1:0]  word,
  input  logic [$clog2(NUM)-1:0] idx,
  output logic [DATA_W-1:0]      lane
);

  localparam int IDX_W = $clog2(NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  logic [DATA_W-1:0] lanes [NUM];
  logic [IDX_W-1:0]  sel;

  for (genvar i = 0; i < NUM; i++) begin : g_lane
    assign lanes[i] = word[i*DATA_W +: DATA_W];
  end

  // NUM is a power of two, so reversing the index never leaves 0..NUM-1
  always_comb begin
    sel  = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;
    lane = lanes[sel];
  end

endmodule

// File: rtl/word_split.sv
// rtl/word_split.sv - splits each accepted NUM*DATA_W word into NUM lanes, one per output transfer; WORD_SPLIT_LAST_EN adds last_out
module word_split
  import word_split_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM       = NUM_DEF,
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst,
  word_split_if.slave bus
);

  localparam int IDX_W = $clog2(NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM*DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0]     lane;
  logic                  ready;
  logic                  sending;

  lane_mux #(
    .DATA_W    (DATA_W),
    .NUM       (NUM),
    .MSB_FIRST (MSB_FIRST)
  ) u_lane_mux (
    .word (word_q),
    .idx  (idx_q),
    .lane (lane)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.valid_in) begin
          word_d  = bus.data_in;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.ready_in) begin
          if (idx_q == LAST_IDX) begin
            // final lane leaving: take the next word in the same cycle for zero-bubble streaming
            ready = 1'b1;
            idx_d = '0;
            if (bus.valid_in) begin
              word_d = bus.data_in;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  assign sending       = (state_q == SEND);
  assign bus.ready_out = ready;
  assign bus.valid_out = sending;
  assign bus.data_out  = sending ? lane : '0;
`ifdef WORD_SPLIT_LAST_EN
  assign bus.last_out  = sending && (idx_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_word_split.sv
// tb/tb_word_split.sv - bench for word_split with LSB-first and MSB-first instances; last_out checked when WORD_SPLIT_LAST_EN is defined
module tb_word_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready_in;
  logic        last0, last1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  word_split_if #(.DATA_W(8), .NUM(4)) if0 ();
  word_split_if #(.DATA_W(8), .NUM(4)) if1 ();

  assign if0.valid_in = valid_in;
  assign if0.data_in  = data_in;
  assign if0.ready_in = ready_in;
  assign if1.valid_in = valid_in;
  assign if1.data_in  = data_in;
  assign if1.ready_in = ready_in;
`ifdef WORD_SPLIT_LAST_EN
  assign last0 = if0.last_out;
  assign last1 = if1.last_out;
`else
  assign last0 = 1'b0;
  assign last1 = 1'b0;
`endif

  word_split #(.DATA_W(8), .NUM(4), .MSB_FIRST(0)) u_lsb (.clk(clk), .rst(rst), .bus(if0.slave));
  word_split #(.DATA_W(8), .NUM(4), .MSB_FIRST(1)) u_msb (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct packed {
    logic [31:0]     word;
    logic [3:0][7:0] lsb;  // lsb[k] = lane expected on k-th output cycle
    logic [3:0][7:0] msb;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic r, input logic l, input logic chk_d);
    chk({tag, ".valid_lsb"}, if0.valid_out, v);
    chk({tag, ".valid_msb"}, if1.valid_out, v);
    chk({tag, ".ready_lsb"}, if0.ready_out, r);
    chk({tag, ".ready_msb"}, if1.ready_out, r);
    if (chk_d) begin
      chk({tag, ".data_lsb"}, if0.data_out, d0);
      chk({tag, ".data_msb"}, if1.data_out, d1);
    end
`ifdef WORD_SPLIT_LAST_EN
    chk({tag, ".last_lsb"}, last0, l);
    chk({tag, ".last_msb"}, last1, l);
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // offer one word from IDLE, then expect its four lanes and a return to IDLE
  task automatic run_word(input string tag, input logic [31:0] w,
                          input logic [3:0][7:0] e0, input logic [3:0][7:0] e1);
    next_cycle();
    valid_in = 1'b1;
    data_in  = w;
    ready_in = 1'b1;
    @(negedge clk);
    chk_out({tag, ".accept"}, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    next_cycle();
    valid_in = 1'b0;
    data_in  = $urandom;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_out($sformatf("%s.lane%0d", tag, k), 1'b1, e0[k], e1[k], k == 3, k == 3, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    chk_out({tag, ".idle"}, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic mchk(input string tag, input logic v, input logic r, input logic l,
                      input logic [7:0] d, input logic [7:0] q[$]);
    chk({tag, ".valid"}, v, q.size() != 0);
    chk({tag, ".ready"}, r, (q.size() == 0) || (q.size() == 1 && ready_in));
    if (q.size() != 0) chk({tag, ".data"}, d, q[0]);
`ifdef WORD_SPLIT_LAST_EN
    chk({tag, ".last"}, l, q.size() == 1);
`endif
  endtask

  initial begin
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       accept;

    vecs[0] = '{32'hDDCCBBAA, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, {8'hAA, 8'hBB, 8'hCC, 8'hDD}};
    vecs[1] = '{32'h11223344, {8'h11, 8'h22, 8'h33, 8'h44}, {8'h44, 8'h33, 8'h22, 8'h11}};
    vecs[2] = '{32'h00FF00FF, {8'h00, 8'hFF, 8'h00, 8'hFF}, {8'hFF, 8'h00, 8'hFF, 8'h00}};
    vecs[3] = '{32'h80000001, {8'h80, 8'h00, 8'h00, 8'h01}, {8'h01, 8'h00, 8'h00, 8'h80}};

    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_out("reset", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) run_word($sformatf("vec%0d", i), vecs[i].word, vecs[i].lsb, vecs[i].msb);

    // back-to-back words; data_in wiggles while the first word is still held
    next_cycle();
    valid_in = 1'b1; data_in = 32'h04030201;
    @(negedge clk);
    chk_out("b2b.accept", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      if (k == 1 || k == 2) data_in = $urandom;
      else if (k < 4) data_in = 32'h08070605;
      else begin valid_in = 1'b0; data_in = $urandom; end
      @(negedge clk);
      chk_out($sformatf("b2b.lane%0d", k), 1'b1, 8'(k + 1), (k < 4) ? 8'(4 - k) : 8'(12 - k),
              k == 3 || k == 7, k == 3 || k == 7, 1'b1);
    end
    next_cycle();
    @(negedge clk);
    chk_out("b2b.idle", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

    // downstream stall on the second lane
    next_cycle();
    valid_in = 1'b1; data_in = 32'hDDCCBBAA;
    next_cycle();
    valid_in = 1'b0;
    @(negedge clk);
    chk_out("stall.lane0", 1'b1, 8'hAA, 8'hDD, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      ready_in = (k == 3);
      @(negedge clk);
      chk_out($sformatf("stall.hold%0d", k), 1'b1, 8'hBB, 8'hCC, 1'b0, 1'b0, 1'b1);
    end
    next_cycle();
    @(negedge clk);
    chk_out("stall.lane2", 1'b1, 8'hCC, 8'hBB, 1'b0, 1'b0, 1'b1);
    next_cycle();
    @(negedge clk);
    chk_out("stall.lane3", 1'b1, 8'hDD, 8'hAA, 1'b1, 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
    chk_out("stall.idle", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

    // reset while the third lane is presented
    next_cycle();
    valid_in = 1'b1; data_in = 32'hDDCCBBAA;
    next_cycle();
    valid_in = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk_out("rstmid.lane2", 1'b1, 8'hCC, 8'hBB, 1'b0, 1'b0, 1'b1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk_out("rstmid.after", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    next_cycle();
    @(negedge clk);
    chk_out("rstmid.quiet", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    run_word("rstmid.new", 32'h11223344, {8'h11, 8'h22, 8'h33, 8'h44}, {8'h44, 8'h33, 8'h22, 8'h11});

    // randomized traffic against a lane-queue model
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      valid_in = 1'($urandom_range(0, 1));
      data_in  = $urandom;
      ready_in = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      mchk("rnd.lsb", if0.valid_out, if0.ready_out, last0, if0.data_out, q0);
      mchk("rnd.msb", if1.valid_out, if1.ready_out, last1, if1.data_out, q1);
      if (rst) begin
        q0.delete();
        q1.delete();
      end else begin
        accept = valid_in && ((q0.size() == 0) || (q0.size() == 1 && ready_in));
        if (ready_in && q0.size() != 0) void'(q0.pop_front());
        if (ready_in && q1.size() != 0) void'(q1.pop_front());
        if (accept) begin
          for (int k = 0; k < 4; k++) begin
            q0.push_back(8'((data_in >> (8 * k)) & 32'hFF));
            q1.push_back(8'((data_in >> (8 * (3 - k))) & 32'hFF));
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_split.md
WORD_SPLIT -- requirements
Module: word_split

Interface
REQ-001 Parameter DATA_W, default 8, width of each output lane.
REQ-002 Parameter NUM, default 4, lanes per input word (power of two, 2..16).
REQ-003 Parameter MSB_FIRST, default 0; 0 emits lane 0 (bits DATA_W-1:0) first, 1 emits the top lane first.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 data_in  input  NUM*DATA_W  packed word to split.
REQ-007 valid_in  input  1  data_in valid.
REQ-008 ready_out  output  1  block can accept a word this cycle.
REQ-009 data_out  output  DATA_W  current lane.
REQ-010 valid_out  output  1  data_out valid.
REQ-011 ready_in  input  1  downstream accepts data_out this cycle.
REQ-012 last_out  output  1  current lane is final lane of word (only with WORD_SPLIT_LAST_EN).

Function
REQ-013 Input handshake: a word is accepted on a cycle with valid_in && ready_out; output handshake: a lane is transferred on a cycle with valid_out && ready_in.
REQ-014 States: IDLE (no word held) and SEND (word held, lane index idx valid).
REQ-015 IDLE: ready_out=1, valid_out=0; on input accept, capture data_in into word register, idx<=0, go to SEND.
REQ-016 SEND: valid_out=1, data_out = lane selected by idx per MSB_FIRST, driven from register (no combinational path from data_in).
REQ-017 SEND with output transfer and idx<NUM-1: idx<=idx+1.
REQ-018 SEND with output transfer and idx==NUM-1: ready_out=1 that cycle; if valid_in, capture new word, idx<=0, stay SEND (zero-bubble back-to-back); else go IDLE.
REQ-019 ready_out=0 in SEND whenever idx!=NUM-1 or ready_in=0; ready_out depends combinationally on ready_in only in that final-lane case.
REQ-020 While valid_out=1 and ready_in=0: data_out, idx, last_out held stable; valid_out not withdrawn.
REQ-021 Latency: first lane valid one cycle after input accept; sustained throughput one lane per cycle with ready_in=1.
REQ-022 idx width $clog2(NUM); idx never exceeds NUM-1.

Reset
REQ-023 rst=1 at a rising edge: state<=IDLE, idx<=0, word register<=0, valid_out=0, data_out=0, last_out=0, ready_out=1 from next cycle.
REQ-024 Reset mid-word discards the held word and remaining lanes; no lane emitted after reset until a new input accept.

Configuration
REQ-025 Macro WORD_SPLIT_LAST_EN defined: last_out port present, =1 exactly when valid_out=1 and idx==NUM-1.
REQ-026 Macro undefined: last_out port and its logic absent; all other behaviour identical.

Structure
REQ-027 Shared package word_split_pkg holds state enum (IDLE, SEND) and default constants DATA_W_DEF=8, NUM_DEF=4.
REQ-028 One sub-module lane_mux (word, idx, MSB_FIRST -> lane) is natural; FSM and handshake stay in word_split.

Verification
REQ-029 Single word 0xDDCCBBAA, MSB_FIRST=0, ready_in=1 -> data_out AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after accept, last_out on DD, then IDLE.
REQ-030 Same word, MSB_FIRST=1 -> DD,CC,BB,AA.
REQ-031 Two words 0x04030201, 0x08070605 offered back-to-back, ready_in=1 -> 8 lanes 01..08 on 8 consecutive cycles, no bubble; ready_out high only on cycles carrying 04 and 08.
REQ-032 ready_in held low 3 cycles while lane BB is presented -> BB, valid_out, last_out stable those 3 cycles; CC follows after ready_in returns.
REQ-033 rst asserted while lane CC presented -> next cycle valid_out=0, data_out=0, ready_out=1; next accepted word 0x11223344 emits 44 first.
REQ-034 valid_in high while SEND idx<NUM-1 -> word not accepted (ready_out=0), data_in changes ignored, held word emitted intact.
